win_linebuf: RTL
================

# win_linebuf

Sliding-window generator for the 5x5 binary convolution engine. It accepts a raster-order 16-bit feature-map stream (28x28 for layer 1, 12x12 for layer 2) and buffers the previous K-1 rows. Every accepted pixel produces one 80-bit column of taps (K rows x 16 bit) in the packing the convolution engine expects. It is the producer end of the `taps` interface and sits between the input/pool feature buffer and the conv block.

## Interface
Parameters:
- `K`, 5: window height; number of rows per tap column.
- `DW`, 16: pixel width.
- `MAXW`, 28: maximum image width; line-buffer depth.

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `start` in 1: level enable. Low means idle with counters cleared.
- `state` in 1: layer select, 0 = width 28, 1 = width 12. Sampled on the IDLE->FILL transition only.
- `din_valid` in 1: pixel strobe.
- `din` in DW: signed pixel, raster order.
- `taps` out K*DW: window column. `taps[79:64]` is row r-4 (oldest) and `taps[15:0]` is row r (current pixel).
- `taps_valid` out 1: `taps` holds a full 5-row column.
- `frame_done` out 1: one-cycle pulse after the last pixel of the frame.
- `err` out 1: sticky overflow flag (see Configuration).

## Operation
- Width W is latched on entry to FILL: 28 if `state`=0, 12 if `state`=1.
- Counters `col` (0..W-1) and `row` (0..W-1) advance only on `din_valid` in FILL or STREAM.
- `col` wraps to 0 at W-1 and increments `row`.
- Line buffers `lb[0..3][0..MAXW-1]`. On an accepted pixel at column c, the buffers shift as a cascade:
  - `lb[3][c]` <= `lb[2][c]`
  - `lb[2][c]` <= `lb[1][c]`
  - `lb[1][c]` <= `lb[0][c]`
  - `lb[0][c]` <= `din`
- `taps` is registered as {lb[3][c], lb[2][c], lb[1][c], lb[0][c], din}, using the pre-shift buffer values.
- FSM:
  - IDLE -> FILL when `start`=1.
  - FILL -> STREAM on the accepted pixel at `row`=K-2, `col`=W-1.
  - STREAM -> DONE on the accepted pixel at `row`=W-1, `col`=W-1.
  - DONE -> IDLE when `start`=0.
  - Any state -> IDLE on the clock edge where `start`=0.
- `taps_valid` is set for accepted pixels in STREAM only. One frame gives (W-K+1)*W valid columns: 672 for W=28, 96 for W=12.
- Pixels with `din_valid` in IDLE or DONE are ignored. Ignoring a pixel in DONE sets `err` when the feature is enabled.
- Line-buffer contents are never reset. FILL always rewrites all four rows before the first valid column.

## Timing
- Reset values: `taps`=0, `taps_valid`=0, `frame_done`=0, `err`=0, FSM=IDLE, `col`=`row`=0.
- Latency: 1 cycle from the `din_valid` edge to `taps`/`taps_valid`.
- `taps_valid` is a per-cycle strobe with no backpressure. The downstream block must accept every strobe.
- `taps` holds its last value when `taps_valid`=0.
- `frame_done` pulses in the same cycle as the final `taps_valid` of the frame.
- Consecutive pixels are allowed every cycle. Gaps of any length between pixels are allowed.
- Toggling `state` mid-frame has no effect until the next IDLE->FILL transition.
- `start` deasserted mid-frame: on the next edge the FSM is IDLE, counters are 0, and `taps_valid`=0. No `frame_done` is generated.
- `start` and `din_valid` in the same cycle while in IDLE: the pixel is dropped. The first pixel is accepted the cycle after FILL is entered.
- `rstn` low at any time: immediate return to the reset values, independent of `clk`.

## Configuration
- `WIN_OVF_CHECK_EN` defined:
  - `err` sets when `din_valid`=1 while in DONE.
  - `err` clears only on `rstn` or on the IDLE->FILL transition.
- `WIN_OVF_CHECK_EN` undefined: `err` is tied to 0 and no check logic is built.

## Test plan
- `state`=0, `start`=1, stream pixels 0..783 back-to-back. Required response:
  - Exactly 672 `taps_valid` strobes.
  - The first valid `taps` is {0,28,56,84,112}.
  - The last valid `taps` is {671,699,727,755,783}.
  - `frame_done` coincides with the last strobe.
- `state`=1, stream pixels 0..143 with one idle cycle after each pixel. Required response:
  - 96 strobes.
  - The first valid `taps` is {0,12,24,36,48}.
  - Each strobe follows its `din_valid` by 1 cycle.
- Negative pixel -5 (0xFFFB) at row 4, col 0. Required response: `taps[15:0]`=0xFFFB with sign preserved, and `taps[79:64]` equals the row-0 col-0 pixel.
- Drop `start` after 200 pixels, then restart with `state`=1 and stream 144 pixels. Required response:
  - No `frame_done` in the aborted frame.
  - The second frame produces 96 strobes with correct tap values.
- With `WIN_OVF_CHECK_EN`, send one extra pixel after `frame_done`. Required response:
  - `err`=1.
  - No `taps_valid`.
  - `err` clears on the next frame start.
- Assert `rstn` low mid-STREAM. Required response: all outputs are 0 immediately, and a following full 28x28 frame is correct.

Source files
------------

// File: rtl/win_linebuf.sv
// Sliding-window line buffer: turns a raster pixel stream into K-row tap columns.
// Optional overflow flag on pixels received after frame end is built when WIN_OVF_CHECK_EN is defined.
module win_linebuf #(
  parameter int unsigned K    = 5,
  parameter int unsigned DW   = 16,
  parameter int unsigned MAXW = 28
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              state,
  input  logic              din_valid,
  input  logic [DW-1:0]     din,
  output logic [K*DW-1:0]   taps,
  output logic              taps_valid,
  output logic              frame_done,
  output logic              err
);

  localparam int unsigned CW = $clog2(MAXW);
  localparam logic [CW-1:0] RowFillEnd = CW'(K - 2);

  typedef enum logic [1:0] {StIdle, StFill, StStream, StDone} st_e;

  st_e             st_q, st_d;
  logic [CW-1:0]   w_q, w_d;
  logic [CW-1:0]   col_q, col_d;
  logic [CW-1:0]   row_q, row_d;
  logic [K*DW-1:0] taps_q;
  logic            tv_q, tv_d;
  logic            fd_q, fd_d;
  logic            enter_fill;
  logic            accept;
  logic            col_last, row_last;

  logic [DW-1:0]       lb [K-1][MAXW];
  logic [(K-1)*DW-1:0] col_rd;

  assign col_last = (col_q == w_q - CW'(1));
  assign row_last = (row_q == w_q - CW'(1));
  assign accept   = start & din_valid & ((st_q == StFill) | (st_q == StStream));

  // Oldest row lands in the top slice so {col_rd, din} matches the conv engine packing.
  always_comb begin
    col_rd = '0;
    for (int i = 0; i < int'(K) - 1; i++) begin
      col_rd[i*DW +: DW] = lb[i][col_q];
    end
  end

  always_comb begin
    st_d       = st_q;
    w_d        = w_q;
    col_d      = col_q;
    row_d      = row_q;
    tv_d       = 1'b0;
    fd_d       = 1'b0;
    enter_fill = 1'b0;
    if (!start) begin
      st_d  = StIdle;
      col_d = '0;
      row_d = '0;
    end else begin
      case (st_q)
        StIdle: begin
          st_d       = StFill;
          w_d        = state ? CW'(12) : CW'(MAXW);
          enter_fill = 1'b1;
          col_d      = '0;
          row_d      = '0;
        end
        StFill, StStream: begin
          if (din_valid) begin
            if (col_last) begin
              col_d = '0;
              row_d = row_q + CW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
            if ((st_q == StFill) && (row_q == RowFillEnd) && col_last) begin
              st_d = StStream;
            end
            if (st_q == StStream) begin
              tv_d = 1'b1;
              if (row_last && col_last) begin
                st_d  = StDone;
                fd_d  = 1'b1;
                col_d = '0;
                row_d = '0;
              end
            end
          end
        end
        StDone:  st_d = StDone;
        default: st_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q   <= StIdle;
      w_q    <= CW'(MAXW);
      col_q  <= '0;
      row_q  <= '0;
      taps_q <= '0;
      tv_q   <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      st_q  <= st_d;
      w_q   <= w_d;
      col_q <= col_d;
      row_q <= row_d;
      tv_q  <= tv_d;
      fd_q  <= fd_d;
      if (tv_d) begin
        taps_q <= {col_rd, din};
      end
    end
  end

  // Buffer contents need no reset: FILL rewrites every row before the first valid column.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 1; i < int'(K) - 1; i++) begin
        lb[i][col_q] <= lb[i-1][col_q];
      end
      lb[0][col_q] <= din;
    end
  end

`ifdef WIN_OVF_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (enter_fill) begin
      err_q <= 1'b0;
    end else if ((st_q == StDone) && din_valid) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign taps       = taps_q;
  assign taps_valid = tv_q;
  assign frame_done = fd_q;

endmodule
